byte_unpack16: RTL and testbench
================================

# byte_unpack16

Byte-lane expander for the DMA write datapath. It takes a stream of left-packed bytes and a stream of 16-bit lane masks. For each mask it emits one 16-byte word with the next packed bytes placed, in order, on the lanes whose mask bit is set. This is the inverse of the prefix-popcount compaction step, used when packed payload is written back to a byte-enabled RAM or bus.

## Interface
- `DATA_WIDTH`, 16: lanes per word (fixed at 16 for this block; byte lanes, 8 bits each)
- `BUF_BYTES`, 32: residue buffer depth in bytes (must be 2*DATA_WIDTH)

- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_data`  in  128  packed bytes; byte k = `s_data[8k+7:8k]`; valid bytes occupy k = 0..s_cnt-1
- `s_cnt`  in  5  number of valid bytes in `s_data`, 0..16
- `s_valid` / `s_ready`  in / out  1  packed-data handshake
- `m_mask`  in  16  lane mask for one output word
- `m_valid` / `m_ready`  in / out  1  mask handshake
- `o_data`  out  128  expanded word; unselected lanes are 0
- `o_strb`  out  16  byte strobes, equal to the consumed mask
- `o_valid` / `o_ready`  out / in  1  output handshake
- `level`  out  6  current buffer occupancy in bytes, 0..32
- `err`  out  1  sticky protocol error (see Configuration)

## Operation
- Internal state:
  - byte buffer `buf[0..31]`, where `buf[0]` is the oldest byte
  - occupancy `cnt`
  - one output register
- Define `pop` = popcount(`m_mask`) and `pre(i)` = popcount(`m_mask[i-1:0]`).
- **Emit.** `m_ready` = `m_valid && cnt >= pop && (!o_valid || o_ready)`. On an emit:
  - `o_data` lane i gets `buf[pre(i)]` if `m_mask[i]`, else 0.
  - `o_strb` gets `m_mask`, and `o_valid` gets 1.
  - The buffer shifts down by `pop`.
- **Accept.** `s_ready` = `(cnt <= 16)`. It depends only on registered `cnt` and has no combinational path from `s_valid`, `m_*` or `o_ready`. On an accept, bytes 0..s_cnt-1 are appended at buffer positions `cnt - pop_emitted`.
- **Simultaneous emit and accept in the same cycle.** The shift is applied first, then the append. Next `cnt` = `cnt - pop_emitted + s_cnt` (never exceeds 32).
- **All-zero mask.** It is consumed immediately when the output slot is free and produces one beat with `o_strb` = 0 and `o_data` = 0. Output beats correspond 1:1 with masks.
- **`s_cnt` = 0 beat.** It is accepted and has no effect on `cnt`.
- **`s_cnt` > 16.** The count is clamped to 16 for buffer purposes. Error handling is per Configuration.
- **Output hold.** The output register holds its value while `o_valid && !o_ready`, and emit is blocked in that state.
- `level` = `cnt`.
- Bytes a mask is waiting on are not bypassed from `s_data` in the same cycle. A mask needs those bytes to be resident in the buffer first.

## Timing
- Reset values:
  - `o_valid` = 0, `o_data` = 0, `o_strb` = 0
  - `cnt`/`level` = 0, `err` = 0
  - buffer contents are don't-care
  - after reset, `s_ready` = 1 and `m_ready` = 0
- If `rst` is asserted mid-stream, all buffered bytes and any pending output beat are discarded on that edge.
- Latency:
  - mask accept to `o_valid` is 1 cycle
  - data accept to earliest emit that uses those bytes is 1 cycle (earliest `m_ready` using them comes on the next cycle)
- Throughput is one output word per cycle when `o_ready` = 1 and data is sufficient. Sustained full-mask (0xFFFF) streaming requires 16 input bytes per cycle. That rate is achievable because `s_ready` stays high while `cnt` ≤ 16.
- Masks are processed strictly in order. A mask with insufficient data blocks later masks.

## Configuration
- Macro: `BYTE_UNPACK_ERR_CHECK_EN`.
- **When defined:**
  - `err` sets, on the clock after an accepted beat with `s_cnt` > 16, and stays set until `rst`.
  - Any bit of `s_data` above byte `s_cnt-1` is ignored either way.
- **When undefined:**
  - `err` is a constant 0 and the check logic is absent.
  - `s_cnt` > 16 is still clamped to 16.

## Test plan
- **Basic expand.** After reset, send `s_data` bytes 0x00..0x0F with `s_cnt` = 16, then mask 0x8001 with `o_ready` = 1.
  - Expect `o_valid` 1 cycle after the mask is accepted.
  - Expect lane 0 = 0x00, lane 15 = 0x01, others 0, `o_strb` = 0x8001, and `level` 16 → 14.
- **Insufficient data.** Send mask 0x00FF with `cnt` = 5.
  - `m_ready` must stay 0.
  - Then send `s_cnt` = 3 (bytes A0..A2). `m_ready` rises the next cycle, and the output lanes 0..7 are the 5 old bytes followed by A0..A2.
- **Backpressure.** Hold `o_ready` = 0 with one beat pending and offer a second mask.
  - `m_ready` = 0 and `o_data` is stable.
  - Release `o_ready`. The second beat appears on the cycle after the handshake.
- **Buffer full.** Accept two 16-byte beats with no masks.
  - `cnt` = 32 and `s_ready` = 0.
  - Send mask 0xFFFF. `cnt` drops to 16 and `s_ready` returns to 1.
- **Simultaneous events and zero mask.** With `cnt` = 10, accept `s_cnt` = 16 and mask 0x0F0F in the same cycle.
  - `level` = 18.
  - Then send mask 0x0000: one beat with `o_strb` = 0 and `level` unchanged.
- **Error and reset.** With the macro defined, send `s_cnt` = 20.
  - `err` = 1 the next cycle and `level` grows by 16.
  - Assert `rst`: `err`, `level` and `o_valid` all return to 0.

Source files
------------

// File: rtl/byte_unpack16.sv
// Byte-lane expander: scatters left-packed bytes onto the set lanes of each 16-bit mask.
// Optional protocol check on s_cnt > 16 enabled by BYTE_UNPACK_ERR_CHECK_EN.

module byte_unpack16_lane #(
  parameter int LANE = 0
) (
  input  logic [15:0]      mask,
  input  logic [15:0][7:0] head,
  output logic [7:0]       lane_byte
);
  logic [3:0] pre;

  // Lane i takes the byte at the popcount of the mask bits below it.
  always_comb begin
    pre = '0;
    for (int k = 0; k < 16; k++)
      if (k < LANE) pre = pre + {3'b0, mask[k]};
    lane_byte = mask[LANE] ? head[pre] : 8'h00;
  end
endmodule

module byte_unpack16 #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_BYTES  = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] s_data,
  input  logic [4:0]   s_cnt,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [15:0]  m_mask,
  input  logic         m_valid,
  output logic         m_ready,
  output logic [127:0] o_data,
  output logic [15:0]  o_strb,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [5:0]   level,
  output logic         err
);
  logic [BUF_BYTES-1:0][7:0]  store, store_nxt;
  logic [DATA_WIDTH-1:0][7:0] lanes, sd;
  logic [5:0] cnt, base, shift;
  logic [4:0] pop, in_cnt;
  logic       emit, acc;

  assign sd    = s_data;
  assign level = cnt;

  always_comb begin
    pop = '0;
    for (int k = 0; k < DATA_WIDTH; k++) pop = pop + {4'b0, m_mask[k]};
  end

  assign in_cnt  = (s_cnt > 5'd16) ? 5'd16 : s_cnt;
  assign s_ready = (cnt <= 6'd16);
  assign m_ready = m_valid && (cnt >= {1'b0, pop}) && (!o_valid || o_ready);
  assign emit    = m_ready;
  assign acc     = s_valid && s_ready;
  assign shift   = emit ? {1'b0, pop} : 6'd0;
  assign base    = cnt - shift;

  // Shift out the emitted bytes first, then append the new beat behind the residue.
  always_comb begin
    logic [5:0] src;
    logic [5:0] off;
    src       = '0;
    off       = '0;
    store_nxt = '0;
    for (int j = 0; j < BUF_BYTES; j++) begin
      src = 6'(j) + shift;
      if (src < 6'(BUF_BYTES)) store_nxt[j] = store[src[4:0]];
    end
    for (int j = 0; j < BUF_BYTES; j++) begin
      off = 6'(j) - base;
      if (acc && (6'(j) >= base) && (off < {1'b0, in_cnt})) store_nxt[j] = sd[off[3:0]];
    end
  end

  always_ff @(posedge clk) store <= store_nxt;

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
    byte_unpack16_lane #(.LANE(g)) u_lane (
      .mask      (m_mask),
      .head      (store[DATA_WIDTH-1:0]),
      .lane_byte (lanes[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_strb  <= '0;
    end else begin
      cnt <= base + {1'b0, acc ? in_cnt : 5'd0};
      if (emit) begin
        o_valid <= 1'b1;
        o_data  <= lanes;
        o_strb  <= m_mask;
      end else if (o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

`ifdef BYTE_UNPACK_ERR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (acc && (s_cnt > 5'd16)) err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_byte_unpack16.sv
// Random-stimulus scoreboard bench for byte_unpack16; reference is a plain byte queue.
module tb_byte_unpack16;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] s_data = '0;
  logic [4:0]   s_cnt = '0;
  logic         s_valid = 1'b0, s_ready;
  logic [15:0]  m_mask = '0;
  logic         m_valid = 1'b0, m_ready;
  logic [127:0] o_data;
  logic [15:0]  o_strb;
  logic         o_valid;
  logic         o_ready = 1'b0;
  logic [5:0]   level;
  logic         err;

  byte_unpack16 dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_cnt(s_cnt), .s_valid(s_valid),
    .s_ready(s_ready), .m_mask(m_mask), .m_valid(m_valid), .m_ready(m_ready),
    .o_data(o_data), .o_strb(o_strb), .o_valid(o_valid), .o_ready(o_ready),
    .level(level), .err(err)
  );

  always #5 clk = ~clk;

  logic [7:0]   bq[$];    // every accepted byte not yet placed on an output lane
  logic [143:0] expq[$];  // {strb, data} of beats emitted but not yet taken
  logic         err_m = 1'b0;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock of stimulus; reports which handshakes the model expects to fire.
  task automatic cycle(input logic sv, input logic [127:0] sd, input logic [4:0] sc,
                       input logic mv, input logic [15:0] mm, input logic ordy,
                       input logic r, output logic mh, output logic sh);
    logic [127:0] d;
    int p, n;
    @(negedge clk);
    rst = r; s_valid = sv; s_data = sd; s_cnt = sc;
    m_valid = mv; m_mask = mm; o_ready = ordy;
    #1;
    p  = $countones(mm);
    mh = mv && (bq.size() >= p) && (expq.size() == 0 || ordy);
    sh = sv && (bq.size() <= 16);
    chk("m_ready", {143'b0, m_ready}, {143'b0, mh});
    chk("s_ready", {143'b0, s_ready}, {143'b0, bq.size() <= 16});
    chk("level",   {138'b0, level},   144'(bq.size()));
    chk("err",     {143'b0, err},     {143'b0, err_m});
    @(posedge clk);
    if (r) begin
      bq.delete(); expq.delete(); err_m = 1'b0;
      mh = 1'b0; sh = 1'b0;
    end else begin
      if (mh) begin
        d = '0;
        for (int i = 0; i < 16; i++)
          if (mm[i]) d[8*i +: 8] = bq.pop_front();
        expq.push_back({mm, d});
      end
      if (sh) begin
        n = (sc > 16) ? 16 : int'(sc);
        for (int k = 0; k < n; k++) bq.push_back(sd[8*k +: 8]);
`ifdef BYTE_UNPACK_ERR_CHECK_EN
        if (sc > 16) err_m = 1'b1;
`endif
      end
    end
  endtask

  // Output monitor: runs after the driver's checks each cycle.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("o_valid", {143'b0, o_valid}, {143'b0, expq.size() != 0});
      if (o_valid && o_ready) begin
        if (expq.size() == 0) chk("beat_unexpected", {o_strb, o_data}, 144'b0);
        else chk("beat", {o_strb, o_data}, expq.pop_front());
      end
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [15:0] rnd_mask();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'($urandom) & 16'($urandom);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic mh, sh, sv, mv, ordy, r;
    logic [127:0] sd, ramp;
    logic [4:0] sc;
    logic [15:0] mm;
    int phase, pv, pm, po;

    cycle(0, '0, 0, 0, 0, 0, 1, mh, sh);
    cycle(0, '0, 0, 0, 0, 0, 1, mh, sh);
    #2;
    chk("rst_o_data",  {16'b0, o_data},  144'b0);
    chk("rst_o_strb",  {128'b0, o_strb}, 144'b0);
    chk("rst_o_valid", {143'b0, o_valid}, 144'b0);

    // Basic expand: bytes 0x00..0x0F then mask 0x8001
    for (int k = 0; k < 16; k++) ramp[8*k +: 8] = 8'(k);
    cycle(1, ramp, 16, 0, 0, 1, 0, mh, sh);
    cycle(0, '0, 0, 1, 16'h8001, 1, 0, mh, sh);
    cycle(0, '0, 0, 0, 0, 1, 0, mh, sh);
    #2;
    chk("basic_data",  {16'b0, o_data}, {16'b0, 8'h01, 112'b0, 8'h00});
    chk("basic_level", {138'b0, level}, 144'd14);

    sv = 0; mv = 0; sd = '0; sc = '0; mm = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      phase = (cyc / 400) % 4;
      case (phase)
        0: begin pv = 90; pm = 30; po = 90;  end
        1: begin pv = 30; pm = 90; po = 90;  end
        2: begin pv = 70; pm = 70; po = 30;  end
        default: begin pv = 60; pm = 60; po = 100; end
      endcase
      if (!sv && $urandom_range(0, 99) < pv) begin
        sv = 1'b1;
        sd = rnd128();
        sc = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(17, 20)) : 5'($urandom_range(0, 16));
      end
      if (!mv && $urandom_range(0, 99) < pm) begin
        mv = 1'b1;
        mm = (phase == 3 && $urandom_range(0, 1) == 1) ? 16'hFFFF : rnd_mask();
      end
      ordy = ($urandom_range(0, 99) < po);
      r    = (cyc == 2000);
      cycle(sv, sd, sc, mv, mm, ordy, r, mh, sh);
      if (mh || r) mv = 1'b0;
      if (sh || r) sv = 1'b0;
    end

    cycle(0, '0, 0, 0, 0, 1, 0, mh, sh);
    cycle(0, '0, 0, 0, 0, 1, 0, mh, sh);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
